pmem_responder: RTL and testbench
=================================

# pmem_responder

Line-granular physical-memory responder for the pmem side of the cache. It accepts 128-bit line reads and writes from one initiator on the pmem_read/pmem_write/pmem_resp handshake. It completes each request after a fixed, parameterized latency and answers from an internal line store. It stands in for main memory beneath the cache in synthesizable test systems, and its latency is deterministic so cache miss and writeback paths can be measured cycle-exactly.

## Interface
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..15
- LINES, 64, number of 128-bit lines stored; power of two, 2..4096
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pmem_read  in  1  line read request; level, held by initiator until pmem_resp
- pmem_write  in  1  line write request; level, held by initiator until pmem_resp
- pmem_address  in  16  byte address; bits [3:0] ignored (line aligned)
- pmem_wdata  in  128  write line data
- pmem_resp  out  1  one-cycle completion pulse
- pmem_rdata  out  128  read line data, valid while pmem_resp=1, held afterwards

## Operation
- Index = pmem_address[$clog2(LINES)+3:4]. Higher address bits are ignored, so addresses alias modulo LINES*16 bytes.
- The store holds LINES x 128-bit data plus one valid bit per line. Reset clears only the valid bits. A read of a line whose valid bit is clear returns 128'h0.
- FSM states:
  - IDLE: if pmem_write or pmem_read is high at an edge, latch the operation, index and wdata, load the counter with LATENCY-1, and go to BUSY.
  - BUSY: decrement the counter. At count 0 go to RESP.
  - RESP: pmem_resp=1. For a write, the store and valid bit are updated at the RESP edge. For a read, pmem_rdata is driven from the store during RESP and registered for hold. Return to IDLE.
- Address, wdata and request-level changes after acceptance are ignored; the latched values are used.
- pmem_read and pmem_write both high at acceptance: the write is performed and the read is dropped.
- A request still high in the cycle after RESP is accepted as a new transaction. The initiator must drop its request on the cycle following pmem_resp.
- Read-after-write to the same line in back-to-back transactions returns the new data.

## Timing
- Reset values: pmem_resp=0, pmem_rdata=128'h0, state=IDLE, counter=0, all valid bits=0.
- Request accepted at edge k: pmem_resp is high for exactly the cycle between edges k+LATENCY and k+LATENCY+1. With LATENCY=1, the response is in the cycle immediately after acceptance.
- Minimum spacing between acceptances is LATENCY+1 edges. Throughput is one line per LATENCY+1 cycles.
- pmem_rdata updates only at the edge entering RESP for a read. It is unchanged by writes and by idle cycles.
- reset_n low mid-transaction: immediate return to IDLE and pmem_resp=0, with the transaction lost. Line data survives, but the cleared valid bits make every line read as 0.
- pmem_resp never asserts in IDLE or BUSY, and never for two consecutive cycles.

## Structure
- Add to lc3b_types:
  - typedef lc3b_line (logic [127:0])
  - enum pmem_resp_state_t {IDLE, BUSY, RESP}
- Sub-module pmem_line_array holds the data array and valid bits:
  - one write port and one read port, indexed
  - asynchronous clear of the valid bits
  - combinational read with zero substitution for invalid lines
- The top level holds the FSM, latency counter and request latches.

## Test plan
- Reset, then read 0x0040 with LATENCY=4 -> pmem_resp 4 cycles after acceptance, pmem_rdata=128'h0.
- Write 0x0120 data 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111, then read 0x012E -> read returns that line, and each resp is exactly 4 cycles after its acceptance.
- Aliasing with LINES=64: write 0x0010=A, then write 0x0410=B, then read 0x0010 -> B.
- pmem_read and pmem_write high together at acceptance with wdata=C at 0x0200 -> one resp only, and a subsequent read of 0x0200 returns C.
- Change pmem_address and pmem_wdata during BUSY -> the originally latched line is written. Assert reset_n low mid-BUSY -> no resp, and a following read of any line returns 0.
- LATENCY=1, three back-to-back reads -> resp every 2nd cycle, never asserted on consecutive cycles.

Source files
------------

// File: rtl/pmem_responder_pkg.sv
// Shared types for the line-granular pmem responder.
// Line type, FSM state encoding and latency counter width.
package pmem_responder_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_resp_state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pmem_responder_if.sv
// pmem request/response bundle between a cache (master) and the responder (slave).
// Requests are level-held by the master; the slave answers with a one-cycle pulse.
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    lc3b_line    pmem_wdata;
    logic        pmem_resp;
    lc3b_line    pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_responder_line_array.sv
// Line store: LINES x 128-bit data with per-line valid bits, one write and one read port.
// Latency: write lands at the clock edge, read is combinational (invalid lines read as zero).
// Backpressure: none; the owner sequences accesses.
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LINES = 64,
    localparam int unsigned IW   = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  lc3b_line      i_wdata,
    input  logic [IW-1:0] i_ridx,
    output lc3b_line      o_rdata
);

    lc3b_line         r_mem [LINES];
    logic [LINES-1:0] r_valid;

    // Data survives reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    assign o_rdata = r_valid[i_ridx] ? r_mem[i_ridx] : '0;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency main-memory stand-in answering 128-bit line reads/writes from one initiator.
// Latency: pmem_resp is high exactly LATENCY cycles after the accepting edge, for one cycle.
// Backpressure: requests are only taken in IDLE or at the RESP edge; others wait at level.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINES   = 64,
    localparam int unsigned IW     = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             reset_n,
    pmem_responder_if.slave  bus
);

    pmem_resp_state_t r_state;
    pmem_resp_state_t w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_write;
    logic [IW-1:0]    r_idx;
    lc3b_line         r_wdata;
    lc3b_line         r_rdata;

    logic             w_req;
    logic             w_accept;
    logic             w_we;
    lc3b_line         w_rd_data;
    logic             w_unused_addr;

    assign w_req = bus.pmem_read | bus.pmem_write;
    // Only the index bits matter; the rest alias.
    assign w_unused_addr = ^bus.pmem_address;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = BUSY;
                    w_accept     = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                // A request still held at this edge starts the next transaction,
                // giving one acceptance every LATENCY+1 cycles.
                if (w_req) begin
                    w_next_state = BUSY;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_is_write <= bus.pmem_write;
                r_idx      <= bus.pmem_address[IW+3:4];
                r_wdata    <= bus.pmem_wdata;
                r_cnt      <= CNT_W'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == BUSY && r_cnt == '0 && !r_is_write) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign w_we = (r_state == RESP) && r_is_write;

    pmem_line_array #(
        .LINES (LINES)
    ) u_line_array (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_ridx  (r_idx),
        .o_rdata (w_rd_data)
    );

    assign bus.pmem_resp  = (r_state == RESP);
    assign bus.pmem_rdata = r_rdata;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_pmem_responder;

    typedef struct packed {
        logic [127:0] rdata;
        int           due;
    } exp_t;

    localparam logic [127:0] D_DEAD = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111;
    localparam logic [127:0] D_A    = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] D_B    = 128'hBBBB_1000_BBBB_2000_BBBB_3000_BBBB_4000;
    localparam logic [127:0] D_C    = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
    localparam logic [127:0] D_E    = 128'h0E0E_1234_0E0E_5678_0E0E_9ABC_0E0E_DEF0;
    localparam logic [127:0] D_D    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4_n;
    logic         rst1_n;
    logic         drv_rd   [2];
    logic         drv_wr   [2];
    logic [15:0]  drv_addr [2];
    logic [127:0] drv_wd   [2];

    pmem_responder_if if4 ();
    pmem_responder_if if1 ();

    assign if4.pmem_read    = drv_rd[0];
    assign if4.pmem_write   = drv_wr[0];
    assign if4.pmem_address = drv_addr[0];
    assign if4.pmem_wdata   = drv_wd[0];
    assign if1.pmem_read    = drv_rd[1];
    assign if1.pmem_write   = drv_wr[1];
    assign if1.pmem_address = drv_addr[1];
    assign if1.pmem_wdata   = drv_wd[1];

    pmem_responder #(.LATENCY(4), .LINES(64)) dut4 (.clk(clk), .reset_n(rst4_n), .bus(if4));
    pmem_responder #(.LATENCY(1), .LINES(64)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(if1));

    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t         q [2][$];
    int           errors = 0;
    int           checks = 0;
    logic [127:0] last  [2];
    int           nresp [2];
    bit           prev  [2];
    int           lat   [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic resp, input logic [127:0] rdata);
        exp_t e;
        if (resp) begin
            nresp[d]++;
            chk($sformatf("dut%0d resp on consecutive cycles", d), 128'(prev[d]), 128'h0);
            checks++;
            if (q[d].size() == 0) begin
                errors++;
                $display("FAIL dut%0d unexpected resp at cycle %0d: got resp 1 expected 0", d, cyc);
            end else begin
                e = q[d].pop_front();
                chk($sformatf("dut%0d resp cycle", d), 128'(cyc), 128'(e.due));
                chk($sformatf("dut%0d rdata", d), rdata, e.rdata);
            end
        end
        prev[d] = resp;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, if4.pmem_resp, if4.pmem_rdata);
            mon(1, if1.pmem_resp, if1.pmem_rdata);
        end
    end

    // One request; expected rdata for writes is the previously read line (held).
    task automatic xact(input int d, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [127:0] wd, input logic [127:0] exp_rd, input bit scramble);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        drv_rd[d] = rd; drv_wr[d] = wr; drv_addr[d] = a; drv_wd[d] = wd;
        @(posedge clk);
        #1;
        e.due = cyc + lat[d];
        if (rd && !wr) last[d] = exp_rd;
        e.rdata = last[d];
        q[d].push_back(e);
        drv_rd[d] = 1'b0; drv_wr[d] = 1'b0;
        if (scramble) begin
            drv_addr[d] = a + 16'h0010;
            drv_wd[d]   = ~wd;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (d == 0) ? if4.pmem_resp : if1.pmem_resp;
        end
        chk($sformatf("dut%0d resp arrived for addr %h", d, a), 128'(seen), 128'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n0;
        int   base;
        exp_t e;
        lat[0] = 4; lat[1] = 1;
        for (int d = 0; d < 2; d++) begin
            drv_rd[d] = 1'b0; drv_wr[d] = 1'b0; drv_addr[d] = '0; drv_wd[d] = '0;
            last[d] = '0; nresp[d] = 0; prev[d] = 1'b0;
        end
        rst4_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset resp dut4", 128'(if4.pmem_resp), 128'h0);
        chk("reset rdata dut4", if4.pmem_rdata, 128'h0);
        chk("reset resp dut1", 128'(if1.pmem_resp), 128'h0);
        chk("reset rdata dut1", if1.pmem_rdata, 128'h0);
        rst4_n = 1'b1;
        rst1_n = 1'b1;
        @(posedge clk);
        #1;

        xact(0, 1, 0, 16'h0040, '0, 128'h0, 0);
        xact(0, 0, 1, 16'h0120, D_DEAD, '0, 0);
        xact(0, 1, 0, 16'h012E, '0, D_DEAD, 0);
        xact(0, 0, 1, 16'h0010, D_A, '0, 0);
        xact(0, 0, 1, 16'h0410, D_B, '0, 0);
        xact(0, 1, 0, 16'h0010, '0, D_B, 0);
        xact(0, 1, 1, 16'h0200, D_C, '0, 0);
        xact(0, 1, 0, 16'h0200, '0, D_C, 0);
        xact(0, 0, 1, 16'h0300, D_E, '0, 1);
        xact(0, 1, 0, 16'h0300, '0, D_E, 0);
        xact(0, 1, 0, 16'h0310, '0, 128'h0, 0);

        // Reset in the middle of a read's BUSY phase.
        drv_rd[0] = 1'b1; drv_addr[0] = 16'h0120;
        @(posedge clk);
        #1;
        drv_rd[0] = 1'b0;
        n0 = nresp[0];
        @(posedge clk);
        #1;
        rst4_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("no resp after mid-BUSY reset", 128'(nresp[0]), 128'(n0));
        chk("rdata cleared by reset", if4.pmem_rdata, 128'h0);
        rst4_n = 1'b1;
        last[0] = '0;
        @(posedge clk);
        #1;
        xact(0, 1, 0, 16'h0120, '0, 128'h0, 0);
        xact(0, 1, 0, 16'h0200, '0, 128'h0, 0);

        // LATENCY=1: three reads with the request held -> resp every 2nd cycle.
        xact(1, 0, 1, 16'h0030, D_D, '0, 0);
        drv_rd[1] = 1'b1; drv_addr[1] = 16'h0030;
        @(posedge clk);
        #1;
        base = cyc;
        last[1] = D_D;
        for (int k = 0; k < 3; k++) begin
            e.rdata = D_D;
            e.due   = base + 1 + 2 * k;
            q[1].push_back(e);
        end
        repeat (4) @(posedge clk);
        #1;
        drv_rd[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("dut4 scoreboard drained", 128'(q[0].size()), 128'h0);
        chk("dut1 scoreboard drained", 128'(q[1].size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
